// File: rtl/circuit4_pkg.sv
// Shared constants and the single-bit circuit_4 gate chain for circuit4_pipe.
package circuit4_pkg;

    localparam int C4_WIDTH  = 8;
    localparam int C4_STAGES = 3;
    localparam int C4_CNT_W  = 16;

    // Same five-gate structure as the original network, kept gate-for-gate.
    function automatic logic c4_eval(input logic a, input logic b, input logic c);
        logic w;
        logic y;
        logic n;
        logic z;
        w = a & b;
        y = w | c;
        n = ~(a | y);
        z = ~(b & n);
        return z ^ c;
    endfunction

endpackage

// File: rtl/circuit4_pipe_stage.sv
// One valid/data pipeline register: captures the upstream slot whenever load is high.
module circuit4_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (load) begin
            valid_reg <= up_valid;
            data_reg  <= up_data;
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;

endmodule

// File: rtl/circuit4_pipe.sv
// Clocked, WIDTH-bit circuit_4 function behind a STAGES-deep valid/ready pipeline.
// Optional transfer counter out_cnt is enabled by defining CIRCUIT4_PIPE_STATS_EN.
module circuit4_pipe
    import circuit4_pkg::*;
#(
    parameter int WIDTH  = C4_WIDTH,
    parameter int STAGES = C4_STAGES,
    parameter int CNT_W  = C4_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o
`ifdef CIRCUIT4_PIPE_STATS_EN
    ,
    output logic [CNT_W-1:0] out_cnt
`endif
);

    logic [WIDTH-1:0]              func_val;
    logic [STAGES-1:0]             load_vec;
    logic [STAGES-1:0]             up_valid;
    logic [STAGES-1:0][WIDTH-1:0]  up_data;
    logic [STAGES-1:0]             valid_q;
    logic [STAGES-1:0][WIDTH-1:0]  data_q;

    genvar gi;

    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_func
            assign func_val[gi] = c4_eval(a[gi], b[gi], c[gi]);
        end

        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            // Stage gi can move when any stage from gi to the tail is empty
            // (bubble collapse) or the consumer takes the tail this cycle.
            assign load_vec[gi] = out_ready | ~(&valid_q[STAGES-1:gi]);

            if (gi == 0) begin : g_head
                assign up_valid[gi] = in_valid;
                assign up_data[gi]  = func_val;
            end else begin : g_body
                assign up_valid[gi] = valid_q[gi-1];
                assign up_data[gi]  = data_q[gi-1];
            end

            circuit4_pipe_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .load     (load_vec[gi]),
                .up_valid (up_valid[gi]),
                .up_data  (up_data[gi]),
                .valid    (valid_q[gi]),
                .data     (data_q[gi])
            );
        end
    endgenerate

    assign in_ready  = load_vec[0];
    assign out_valid = valid_q[STAGES-1];
    assign o         = data_q[STAGES-1];

`ifdef CIRCUIT4_PIPE_STATS_EN
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (out_valid && out_ready) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign out_cnt = cnt_reg;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule
